mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning ack wait limit in cycles (8-bit, 1..255).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous reset, active low.
REQ-005 SHALL have port if_ce_i  in  1  fetch read request.
REQ-006 SHALL have port if_addr_i  in  32  fetch address.
REQ-007 SHALL have port if_data_o  out  32  fetch read data.
REQ-008 SHALL have port stallreq_if_o  out  1  fetch stall request.
REQ-009 SHALL have ports mem_ce_i / mem_we_i  in  1 / 1  data-port request / write enable.
REQ-010 SHALL have ports mem_addr_i / mem_sel_i / mem_data_i  in  32 / 4 / 32  data-port address, byte select, write data.
REQ-011 SHALL have port mem_data_o  out  32  data-port read data (raw word; byte/half extraction stays in the mem stage).
REQ-012 SHALL have port stallreq_mem_o  out  1  data-port stall request.
REQ-013 SHALL have ports bus_ce_o / bus_we_o / bus_addr_o / bus_sel_o / bus_wdata_o  out  1 / 1 / 32 / 4 / 32  shared SRAM bus.
REQ-014 SHALL have ports bus_rdata_i / bus_ack_i  in  32 / 1  SRAM read data, one-cycle completion strobe.
REQ-015 SHALL have port timeout_o  out  1  sticky bus-timeout flag.

Function
REQ-016 SHALL implement FSM IDLE, IF_ACC, MEM_ACC, DONE; state plus owner (IF/MEM) and last_owner registers.
REQ-017 IDLE: request only from mem -> MEM_ACC; only from if -> IF_ACC; both -> port != last_owner; none -> stay.
REQ-018 On grant, SHALL latch addr/we/sel/wdata of the winner; fetch grant latches we=0, sel=4'b1111.
REQ-019 In *_ACC, bus_ce_o=1 with latched values; all bus outputs SHALL be 0 in IDLE and DONE.
REQ-020 In *_ACC with bus_ack_i=1: capture bus_rdata_i into the owner's data_o register (reads only), go DONE, update last_owner.
REQ-021 DONE SHALL last exactly one cycle, then IDLE.
REQ-022 stallreq_x_o = x_ce_i AND NOT (state==DONE AND owner==x), combinational.
REQ-023 Minimum latency: request cycle 0 (IDLE), ack cycle 1, stall released cycle 2.
REQ-024 if_data_o / mem_data_o SHALL hold until the next capture for that port; writes SHALL NOT update mem_data_o.
REQ-025 Requester input changes during *_ACC SHALL NOT affect bus outputs.
REQ-026 bus_ack_i in IDLE or DONE SHALL be ignored.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, owner=IF, last_owner=IF, all data_o=0, bus outputs 0, timeout_o=0.
REQ-028 Reset mid-access SHALL drop bus_ce_o the same cycle; the access SHALL NOT be reissued after reset.

Configuration
REQ-029 Macro MEM_ARB_TIMEOUT_EN defined: 8-bit counter clears on grant, increments each *_ACC cycle without ack; reaching TIMEOUT_CYCLES SHALL go DONE, capture 0 for reads, set timeout_o until reset.
REQ-030 MEM_ARB_TIMEOUT_EN undefined: *_ACC SHALL wait indefinitely; timeout_o tied 0; no counter logic.

Verification
REQ-031 if_ce_i=1, addr=0x100, ack in cycle 1 with rdata=0xDEADBEEF -> bus_addr_o=0x100 cycle 1, if_data_o=0xDEADBEEF, stallreq_if_o low cycle 2.
REQ-032 Both requests in same cycle after reset (last_owner=IF) -> MEM granted first, IF granted in the following IDLE; both complete within 6 cycles with ack each access cycle.
REQ-033 mem SB write addr=0x203, sel=4'b0001, wdata=0x5A5A5A5A, ack after 3 wait cycles -> bus_we_o=1 held 4 cycles, mem_data_o unchanged.
REQ-034 rst low during MEM_ACC -> bus_ce_o=0 immediately; after release, state IDLE, outputs 0.
REQ-035 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DONE after 4 access cycles, mem_data_o=0, timeout_o=1 until reset; without macro, still in MEM_ACC after 300 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch read port and a data port (read/write)
//   onto one shared SRAM bus. Only one access is in flight at a time.
//   When both ports request in the same IDLE cycle, the port that did not
//   own the previous access wins (last_owner alternation).
//   Bus outputs are registered. They are loaded from the winner's request
//   on grant and cleared when the access ends, so requester changes during
//   an access never reach the bus.
//   Build macro MEM_ARB_TIMEOUT_EN: enables the ack-wait timeout counter and
//   the sticky timeout_o flag. Without it an access waits for ack forever.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        stallreq_if_o,
  // data port
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_mem_o,
  // shared SRAM bus
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  // sticky bus-timeout flag
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_ACC  = 2'd1,
    S_MEM_ACC = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Reject ack wait limits outside the 8-bit counter range at elaboration.
  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        grant_mem_s;
  logic        grant_if_s;
  logic        access_end_s;

`ifdef MEM_ARB_TIMEOUT_EN
  // The access gives up in the cycle where the counter already holds
  // TIMEOUT_CYCLES-1 and still no ack arrives, i.e. after TIMEOUT_CYCLES
  // access cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // The data port wins when alone or when the fetch port owned the last access.
  assign grant_mem_s = mem_ce_i & (~if_ce_i | (last_owner_q == OWN_IF));
  assign grant_if_s  = if_ce_i & ~grant_mem_s;

  // Next-state, bus latch, read-data capture and timeout bookkeeping.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bus_ce_d     = bus_ce_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    access_end_s = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_mem_s) begin
          state_d     = S_MEM_ACC;
          owner_d     = OWN_MEM;
          bus_ce_d    = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_sel_d   = mem_sel_i;
          bus_wdata_d = mem_data_i;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (grant_if_s) begin
          state_d     = S_IF_ACC;
          owner_d     = OWN_IF;
          bus_ce_d    = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_sel_d   = 4'b1111;
          bus_wdata_d = 32'h0000_0000;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_IF_ACC, S_MEM_ACC: begin
        if (bus_ack_i) begin
          access_end_s = 1'b1;
          // Only reads return data; a write leaves both data registers alone.
          if (!bus_we_q) begin
            if (owner_q == OWN_MEM) begin
              mem_data_d = bus_rdata_i;
            end else begin
              if_data_d = bus_rdata_i;
            end
          end else begin
            mem_data_d = mem_data_q;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Abandoned access: a read returns zero so the core does not see stale data.
          access_end_s = 1'b1;
          timeout_d    = 1'b1;
          if (!bus_we_q) begin
            if (owner_q == OWN_MEM) begin
              mem_data_d = 32'h0000_0000;
            end else begin
              if_data_d = 32'h0000_0000;
            end
          end else begin
            mem_data_d = mem_data_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        else begin
          state_d = state_q;
        end
`endif
      end

      S_DONE: begin
        // One-cycle completion window; the owner's stall drops here.
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        bus_ce_d = 1'b0;
      end
    endcase

    // Common access wrap-up: release the bus and remember who owned it.
    if (access_end_s) begin
      state_d      = S_DONE;
      last_owner_d = owner_q;
      bus_ce_d     = 1'b0;
      bus_we_d     = 1'b0;
      bus_addr_d   = 32'h0000_0000;
      bus_sel_d    = 4'b0000;
      bus_wdata_d  = 32'h0000_0000;
    end else begin
      last_owner_d = last_owner_d;
    end
  end

  // State, ownership, bus and read-data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      bus_ce_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_sel_q    <= 4'b0000;
      bus_wdata_q  <= 32'h0000_0000;
      if_data_q    <= 32'h0000_0000;
      mem_data_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bus_ce_q     <= bus_ce_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      if_data_q    <= if_data_d;
      mem_data_q   <= mem_data_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Ack-wait counter and sticky timeout flag; only a reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Stall each requester until its own access reaches DONE.
  assign stallreq_if_o  = if_ce_i  & ~((state_q == S_DONE) & (owner_q == OWN_IF));
  assign stallreq_mem_o = mem_ce_i & ~((state_q == S_DONE) & (owner_q == OWN_MEM));

  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign bus_ce_o    = bus_ce_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single-port accesses checked through a
// scoreboard queue, plus hand-written sequences for arbitration, reset
// during an access, ack outside an access and the ack-wait limit.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 32'd4;
`else
  localparam int unsigned TB_TO = 32'd255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        stallreq_if_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_mem_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        timeout_o;

  mem_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_data_o     (if_data_o),
    .stallreq_if_o (stallreq_if_o),
    .mem_ce_i      (mem_ce_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sel_i     (mem_sel_i),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_ce_o      (bus_ce_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_sel_o     (bus_sel_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        scramble;
    logic        exp_we;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t        vecs[6];
  vec_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_ce_i     = 1'b0;
    if_addr_i   = 32'h0;
    mem_ce_i    = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h0;
    mem_sel_i   = 4'h0;
    mem_data_i  = 32'h0;
    bus_rdata_i = 32'h0;
    bus_ack_i   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rst_bus_ce", {31'd0, bus_ce_o}, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    exp_if_data  = 32'h0;
    exp_mem_data = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One access through the scoreboard: push on drive, pop in DONE.
  task automatic run_vec(input vec_t v);
    vec_t cur;
    bit   seen;
    @(negedge clk);
    if (v.is_mem) begin
      mem_ce_i = 1'b1; mem_we_i = v.we; mem_addr_i = v.addr;
      mem_sel_i = v.sel; mem_data_i = v.wdata;
    end else begin
      if_ce_i = 1'b1; if_addr_i = v.addr;
      mem_we_i = 1'b1; mem_sel_i = 4'h6; mem_data_i = 32'h7777_7777;
    end
    sb_q.push_back(v);
    #1;
    chk("stall_req_c0", {31'd0, (v.is_mem ? stallreq_mem_o : stallreq_if_o)}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus_ce_o) seen = 1'b1;
    end
    chk("grant_seen", {31'd0, seen}, 32'd1);
    cur = sb_q.pop_front();
    if (seen) begin
      for (int w = 0; w <= cur.waits; w++) begin
        chk("acc_bus_ce", {31'd0, bus_ce_o}, 32'd1);
        chk("acc_bus_addr", bus_addr_o, cur.addr);
        chk("acc_bus_we", {31'd0, bus_we_o}, {31'd0, cur.exp_we});
        chk("acc_bus_sel", {28'd0, bus_sel_o}, {28'd0, cur.exp_sel});
        if (cur.is_mem) chk("acc_bus_wdata", bus_wdata_o, cur.wdata);
        chk("acc_stall", {31'd0, (cur.is_mem ? stallreq_mem_o : stallreq_if_o)}, 32'd1);
        if (cur.scramble) begin
          if (cur.is_mem) begin
            mem_addr_i = ~cur.addr; mem_we_i = ~cur.we;
            mem_sel_i = ~cur.sel; mem_data_i = ~cur.wdata;
          end else begin
            if_addr_i = ~cur.addr;
          end
        end
        if (w == cur.waits) begin
          bus_ack_i = 1'b1; bus_rdata_i = cur.rdata;
        end else begin
          bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0_0000 | w;
        end
        @(negedge clk);
      end
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0BAD_F00D;
      if (!cur.we || !cur.is_mem) begin
        if (cur.is_mem) exp_mem_data = cur.rdata;
        else            exp_if_data  = cur.rdata;
      end
      chk("done_stall", {31'd0, (cur.is_mem ? stallreq_mem_o : stallreq_if_o)}, 32'd0);
      chk("done_bus_ce", {31'd0, bus_ce_o}, 32'd0);
      chk("done_bus_we", {31'd0, bus_we_o}, 32'd0);
      chk("done_if_data", if_data_o, exp_if_data);
      chk("done_mem_data", mem_data_o, exp_mem_data);
    end
    idle_inputs();
    @(negedge clk);
    chk("idle_bus_ce", {31'd0, bus_ce_o}, 32'd0);
    chk("idle_bus_addr", bus_addr_o, 32'd0);
  endtask

  // Simultaneous requests; mem_first tells which port the alternation favours.
  task automatic both_req(input bit mem_first);
    @(negedge clk);
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0300;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0500;
    mem_sel_i = 4'hF; mem_data_i = 32'h0;
    @(negedge clk);
    chk("both_c1_ce", {31'd0, bus_ce_o}, 32'd1);
    chk("both_c1_addr", bus_addr_o, mem_first ? 32'h0000_0500 : 32'h0000_0300);
    chk("both_c1_stall_if", {31'd0, stallreq_if_o}, 32'd1);
    chk("both_c1_stall_mem", {31'd0, stallreq_mem_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("both_c2_stall_first", {31'd0, (mem_first ? stallreq_mem_o : stallreq_if_o)}, 32'd0);
    chk("both_c2_stall_second", {31'd0, (mem_first ? stallreq_if_o : stallreq_mem_o)}, 32'd1);
    if (mem_first) begin exp_mem_data = 32'h1111_2222; mem_ce_i = 1'b0; end
    else begin exp_if_data = 32'h1111_2222; if_ce_i = 1'b0; end
    chk("both_c2_if_data", if_data_o, exp_if_data);
    chk("both_c2_mem_data", mem_data_o, exp_mem_data);
    @(negedge clk);
    chk("both_c3_idle_ce", {31'd0, bus_ce_o}, 32'd0);
    @(negedge clk);
    chk("both_c4_ce", {31'd0, bus_ce_o}, 32'd1);
    chk("both_c4_addr", bus_addr_o, mem_first ? 32'h0000_0300 : 32'h0000_0500);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_4444;
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("both_c5_stall_second", {31'd0, (mem_first ? stallreq_if_o : stallreq_mem_o)}, 32'd0);
    if (mem_first) exp_if_data = 32'h3333_4444;
    else           exp_mem_data = 32'h3333_4444;
    chk("both_c5_if_data", if_data_o, exp_if_data);
    chk("both_c5_mem_data", mem_data_o, exp_mem_data);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //         is_mem we    addr          sel   wdata         rdata        waits scr   exp_we exp_sel
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 1'b0, 4'hF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0203, 4'h1, 32'h5A5A_5A5A, 32'h1111_1111, 3, 1'b0, 1'b1, 4'h1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h2468_ACE0, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 4'hF};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'h0123_4567, 2, 1'b1, 1'b0, 4'hF};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 4'hC, 32'hA5A5_FFFF, 32'h9999_9999, 0, 1'b0, 1'b1, 4'hC};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0008, 4'h3, 32'h0,        32'h8765_4321, 0, 1'b0, 1'b0, 4'h3};

    idle_inputs();
    rst = 1'b0;
    exp_if_data  = 32'h0;
    exp_mem_data = 32'h0;
    apply_reset();
    chk("post_rst_stall_if", {31'd0, stallreq_if_o}, 32'd0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Tie after reset goes to the data port, then the fetch port.
    apply_reset();
    both_req(1'b1);
    // A data-port access makes the fetch port the favoured one next tie.
    run_vec(vecs[5]);
    both_req(1'b0);

    // Ack with no access in progress changes nothing.
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_0000;
    @(negedge clk);
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_ack_if_data", if_data_o, exp_if_data);
    chk("idle_ack_mem_data", mem_data_o, exp_mem_data);
    chk("idle_ack_bus_ce", {31'd0, bus_ce_o}, 32'd0);

    // Reset in the middle of a data-port access.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0700; mem_sel_i = 4'hF;
    @(negedge clk);
    chk("midrst_ce_before", {31'd0, bus_ce_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ce_now", {31'd0, bus_ce_o}, 32'd0);
    chk("midrst_addr_now", bus_addr_o, 32'd0);
    chk("midrst_mem_data", mem_data_o, 32'd0);
    chk("midrst_if_data", if_data_o, 32'd0);
    exp_if_data = 32'h0; exp_mem_data = 32'h0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_reissue", {31'd0, bus_ce_o}, 32'd0);
    end

    // Ack-wait limit behaviour.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0900; mem_sel_i = 4'hF;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("to_acc_ce", {31'd0, bus_ce_o}, 32'd1);
      chk("to_acc_flag", {31'd0, timeout_o}, 32'd0);
    end
    @(negedge clk);
    chk("to_done_ce", {31'd0, bus_ce_o}, 32'd0);
    chk("to_done_mem_data", mem_data_o, 32'd0);
    chk("to_done_flag", {31'd0, timeout_o}, 32'd1);
    chk("to_done_stall", {31'd0, stallreq_mem_o}, 32'd0);
    idle_inputs();
    repeat (5) @(negedge clk);
    chk("to_sticky", {31'd0, timeout_o}, 32'd1);
    apply_reset();
    chk("to_cleared", {31'd0, timeout_o}, 32'd0);
`else
    repeat (300) @(negedge clk);
    chk("wait300_ce", {31'd0, bus_ce_o}, 32'd1);
    chk("wait300_addr", bus_addr_o, 32'h0000_0900);
    chk("wait300_stall", {31'd0, stallreq_mem_o}, 32'd1);
    chk("wait300_timeout", {31'd0, timeout_o}, 32'd0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h600D_600D;
    @(negedge clk);
    bus_ack_i = 1'b0;
    chk("wait300_mem_data", mem_data_o, 32'h600D_600D);
    idle_inputs();
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
